// File: rtl/dmem_access_unit_pkg.sv
// Shared types and decode helpers for the MEM-stage data-memory access unit.
package dmem_access_unit_pkg;

    typedef enum logic [1:0] {
        DMEM_IDLE,
        DMEM_BUSY,
        DMEM_DONE
    } dmem_state_e;

    // Access size as encoded in funct3[1:0].
    typedef enum logic [1:0] {
        MEM_B = 2'b00,
        MEM_H = 2'b01,
        MEM_W = 2'b10,
        MEM_D = 2'b11
    } mem_size_e;

    function automatic logic [7:0] size_mask(input mem_size_e size);
        case (size)
            MEM_B:   size_mask = 8'h01;
            MEM_H:   size_mask = 8'h03;
            MEM_W:   size_mask = 8'h0F;
            default: size_mask = 8'hFF;
        endcase
    endfunction

    function automatic logic funct3_legal(input logic is_load, input logic [2:0] funct3,
                                          input logic rv64);
        if (is_load) begin
            case (funct3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: funct3_legal = 1'b1;
                3'b011, 3'b110:                         funct3_legal = rv64;
                default:                                funct3_legal = 1'b0;
            endcase
        end else begin
            case (funct3)
                3'b000, 3'b001, 3'b010: funct3_legal = 1'b1;
                3'b011:                 funct3_legal = rv64;
                default:                funct3_legal = 1'b0;
            endcase
        end
    endfunction

    function automatic logic misaligned(input mem_size_e size, input logic [2:0] addr_lo);
        case (size)
            MEM_B:   misaligned = 1'b0;
            MEM_H:   misaligned = addr_lo[0];
            MEM_W:   misaligned = |addr_lo[1:0];
            default: misaligned = |addr_lo;
        endcase
    endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Load result formatter: picks the addressed lane of the memory word and
// sign- or zero-extends it to XLEN according to funct3.
module dmem_load_align
    import dmem_access_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0]           rdata_i,
    input  logic [$clog2(XLEN/8)-1:0] offset_i,
    input  logic [2:0]                funct3_i,
    output logic [XLEN-1:0]           data_o
);

    logic [XLEN-1:0] lane;
    assign lane = rdata_i >> {offset_i, 3'b000};

    // funct3[2] selects zero extension (lbu/lhu/lwu).
    always_comb begin
        case (mem_size_e'(funct3_i[1:0]))
            MEM_B:   data_o = funct3_i[2] ? XLEN'(lane[7:0])  : XLEN'($signed(lane[7:0]));
            MEM_H:   data_o = funct3_i[2] ? XLEN'(lane[15:0]) : XLEN'($signed(lane[15:0]));
            MEM_W:   data_o = funct3_i[2] ? XLEN'(lane[31:0]) : XLEN'($signed(lane[31:0]));
            default: data_o = lane;
        endcase
    end

endmodule

// File: rtl/dmem_access_unit.sv
// MEM-stage data-memory access engine: holds one request until data_resp (or
// timeout), stalls the pipeline meanwhile, and returns one formatted result.
module dmem_access_unit
    import dmem_access_unit_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    input  logic              req_read_i,
    input  logic              req_write_i,
    input  logic [2:0]        req_funct3_i,
    input  logic [XLEN-1:0]   req_addr_i,
    input  logic [XLEN-1:0]   req_wdata_i,
    input  logic              flush_i,
    input  logic              data_resp_i,
    input  logic [XLEN-1:0]   data_rdata_i,
    output logic              data_read_o,
    output logic              data_write_o,
    output logic [XLEN/8-1:0] data_mbe_o,
    output logic [XLEN-1:0]   data_addr_o,
    output logic [XLEN-1:0]   data_wdata_o,
    output logic              stall_o,
    output logic              rsp_valid_o,
    output logic [XLEN-1:0]   rsp_rdata_o,
    output logic              access_fault_o,
    output logic              timeout_err_o
);

    localparam int NB    = XLEN / 8;
    localparam int OFFW  = $clog2(NB);
    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    dmem_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             read_q, read_d;
    logic             write_q, write_d;
    logic             fault_q, fault_d;
    logic             timeout_q, timeout_d;
    logic [2:0]       funct3_q, funct3_d;
    logic [XLEN-1:0]  addr_q, addr_d;
    logic [XLEN-1:0]  wdata_q, wdata_d;
    logic [XLEN-1:0]  rdata_q, rdata_d;

    logic            accept;
    logic            req_fault;
    logic            timeout_hit;
    logic [OFFW-1:0] offset_q;
    logic [XLEN-1:0] load_data;

    assign offset_q = addr_q[OFFW-1:0];

    assign accept = !rst_i && req_valid_i && (req_read_i || req_write_i) && !flush_i;

    assign req_fault = (req_read_i && req_write_i)
                    || !funct3_legal(req_read_i, req_funct3_i, XLEN == 64)
                    || misaligned(mem_size_e'(req_funct3_i[1:0]), req_addr_i[2:0]);

    assign timeout_hit = (TIMEOUT_CYC != 0) && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

    dmem_load_align #(.XLEN(XLEN)) u_load_align (
        .rdata_i  (rdata_q),
        .offset_i (offset_q),
        .funct3_i (funct3_q),
        .data_o   (load_data)
    );

    // NOTE: every next-state and output gets a default before the case, so no path can infer a latch.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        read_d         = read_q;
        write_d        = write_q;
        fault_d        = fault_q;
        timeout_d      = timeout_q;
        funct3_d       = funct3_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        rdata_d        = rdata_q;
        data_read_o    = 1'b0;
        data_write_o   = 1'b0;
        data_mbe_o     = '0;
        data_addr_o    = '0;
        data_wdata_o   = '0;
        stall_o        = 1'b0;
        rsp_valid_o    = 1'b0;
        rsp_rdata_o    = '0;
        access_fault_o = 1'b0;
        timeout_err_o  = 1'b0;

        case (state_q)
            DMEM_IDLE: begin
                if (accept) begin
                    stall_o   = 1'b1;
                    read_d    = req_read_i;
                    write_d   = req_write_i;
                    funct3_d  = req_funct3_i;
                    addr_d    = req_addr_i;
                    wdata_d   = req_wdata_i;
                    fault_d   = req_fault;
                    timeout_d = 1'b0;
                    cnt_d     = '0;
                    state_d   = req_fault ? DMEM_DONE : DMEM_BUSY;
                end
            end
            DMEM_BUSY: begin
                stall_o      = 1'b1;
                data_read_o  = read_q;
                data_write_o = write_q;
                data_addr_o  = {addr_q[XLEN-1:OFFW], OFFW'(0)};
                data_mbe_o   = NB'(size_mask(mem_size_e'(funct3_q[1:0]))) << offset_q;
                data_wdata_o = wdata_q << {offset_q, 3'b000};
                // A response arriving on the timeout cycle still completes normally.
                if (data_resp_i) begin
                    rdata_d = data_rdata_i;
                    state_d = DMEM_DONE;
                end else if (timeout_hit) begin
                    timeout_d = 1'b1;
                    state_d   = DMEM_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DMEM_DONE: begin
                rsp_valid_o    = 1'b1;
                access_fault_o = fault_q;
                timeout_err_o  = timeout_q;
                rsp_rdata_o    = (read_q && !fault_q && !timeout_q) ? load_data : '0;
                state_d        = DMEM_IDLE;
            end
            default: state_d = DMEM_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= DMEM_IDLE;
            cnt_q     <= '0;
            read_q    <= 1'b0;
            write_q   <= 1'b0;
            fault_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            read_q    <= read_d;
            write_q   <= write_d;
            fault_q   <= fault_d;
            timeout_q <= timeout_d;
        end
    end

    // NOTE: datapath registers are left unreset; every consumer is gated by state_q.
    always_ff @(posedge clk_i) begin
        funct3_q <= funct3_d;
        addr_q   <= addr_d;
        wdata_q  <= wdata_d;
        rdata_q  <= rdata_d;
    end

endmodule
